// File: rtl/control_unit_v2.sv
// Multi-cycle fetch/decode/execute controller for an 8-opcode ISA.
// Memory-ready stalls, illegal-opcode trap and a saturating retired-instruction counter.
module control_unit_v2 #(
  parameter  int RAW  = 4,
  parameter  int DAW  = 8,
  parameter  int ALUW = 3,
  parameter  int CNTW = 16,
  localparam int IW   = 4 + 3*RAW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IW-1:0]   ir,
  input  logic            rf_ra_zero,
  input  logic            mem_ready,
  output logic            pc_clr,
  output logic            pc_up,
  output logic            pc_ld,
  output logic [DAW-1:0]  pc_offset,
  output logic            ir_ld,
  output logic [DAW-1:0]  d_addr,
  output logic            d_wr,
  output logic [1:0]      rf_sel,
  output logic [DAW-1:0]  rf_imm,
  output logic [RAW-1:0]  rf_w_addr,
  output logic            rf_w_en,
  output logic [RAW-1:0]  rf_ra_addr,
  output logic [RAW-1:0]  rf_rb_addr,
  output logic [ALUW-1:0] alu_sel,
  output logic            halted,
  output logic            illegal,
  output logic [CNTW-1:0] retired,
  output logic [3:0]      state
);

  localparam logic [3:0] S_INIT   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_NOOP   = 4'd3;
  localparam logic [3:0] S_LOAD_A = 4'd4;
  localparam logic [3:0] S_LOAD_B = 4'd5;
  localparam logic [3:0] S_STORE  = 4'd6;
  localparam logic [3:0] S_ADD    = 4'd7;
  localparam logic [3:0] S_SUB    = 4'd8;
  localparam logic [3:0] S_HALT   = 4'd9;
  localparam logic [3:0] S_LDC    = 4'd10;
  localparam logic [3:0] S_JPZ    = 4'd11;

  localparam logic [ALUW-1:0] ALU_ADD = ALUW'(2'd1);
  localparam logic [ALUW-1:0] ALU_SUB = ALUW'(2'd2);
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [3:0]      state_r;
  logic [3:0]      next_state_s;
  logic [CNTW-1:0] retired_r;
  logic            illegal_r;
  logic            retire_s;

  logic [3:0]      opcode_s;
  logic [RAW-1:0]  fld_a_s;
  logic [RAW-1:0]  fld_b_s;
  logic [RAW-1:0]  fld_d_s;
  logic [DAW-1:0]  fld_lo_s;
  logic [DAW-1:0]  fld_hi_s;

  assign opcode_s = ir[IW-1:IW-4];
  assign fld_a_s  = ir[3*RAW-1:2*RAW];
  assign fld_b_s  = ir[2*RAW-1:RAW];
  assign fld_d_s  = ir[RAW-1:0];
  assign fld_lo_s = ir[DAW-1:0];
  assign fld_hi_s = ir[3*RAW-1:RAW];

  assign state   = state_r;
  assign retired = retired_r;
  assign illegal = illegal_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Retired-instruction counter, saturating at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_r <= {CNTW{1'b0}};
    end else if (retire_s && !(&retired_r)) begin
      retired_r <= retired_r + CNT_ONE;
    end else begin
      retired_r <= retired_r;
    end
  end

  // Sticky illegal-opcode flag, set on the decode edge into HALT
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_r <= 1'b0;
    end else if ((state_r == S_DECODE) && opcode_s[3]) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_INIT:   next_state_s = S_FETCH;
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: begin
        case (opcode_s)
          4'd0:    next_state_s = S_NOOP;
          4'd1:    next_state_s = S_STORE;
          4'd2:    next_state_s = S_LOAD_A;
          4'd3:    next_state_s = S_ADD;
          4'd4:    next_state_s = S_SUB;
          4'd5:    next_state_s = S_HALT;
          4'd6:    next_state_s = S_LDC;
          4'd7:    next_state_s = S_JPZ;
          default: next_state_s = S_HALT;
        endcase
      end
      S_NOOP:   next_state_s = S_FETCH;
      S_STORE: begin
        if (mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_STORE;
        end
      end
      S_LOAD_A: next_state_s = S_LOAD_B;
      S_LOAD_B: begin
        if (mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_LOAD_B;
        end
      end
      S_ADD:    next_state_s = S_FETCH;
      S_SUB:    next_state_s = S_FETCH;
      S_LDC:    next_state_s = S_FETCH;
      S_JPZ:    next_state_s = S_FETCH;
      S_HALT:   next_state_s = S_HALT;
      // Unused encodings recover through INIT
      default:  next_state_s = S_INIT;
    endcase
  end

  // An instruction retires when an execute state hands back to FETCH
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      S_NOOP, S_STORE, S_LOAD_B, S_ADD, S_SUB, S_LDC, S_JPZ:
        retire_s = (next_state_s == S_FETCH);
      default:
        retire_s = 1'b0;
    endcase
  end

  // Output decode: every output defaults to zero in every state
  always_comb begin
    pc_clr     = 1'b0;
    pc_up      = 1'b0;
    pc_ld      = 1'b0;
    pc_offset  = {DAW{1'b0}};
    ir_ld      = 1'b0;
    d_addr     = {DAW{1'b0}};
    d_wr       = 1'b0;
    rf_sel     = 2'd0;
    rf_imm     = {DAW{1'b0}};
    rf_w_addr  = {RAW{1'b0}};
    rf_w_en    = 1'b0;
    rf_ra_addr = {RAW{1'b0}};
    rf_rb_addr = {RAW{1'b0}};
    alu_sel    = {ALUW{1'b0}};
    halted     = 1'b0;
    case (state_r)
      S_INIT:  pc_clr = 1'b1;
      S_FETCH: begin
        pc_up = 1'b1;
        ir_ld = 1'b1;
      end
      S_STORE: begin
        d_addr     = fld_lo_s;
        rf_ra_addr = fld_a_s;
        d_wr       = 1'b1;
      end
      S_LOAD_A: begin
        d_addr    = fld_hi_s;
        rf_sel    = 2'd1;
        rf_w_addr = fld_d_s;
      end
      S_LOAD_B: begin
        d_addr    = fld_hi_s;
        rf_sel    = 2'd1;
        rf_w_addr = fld_d_s;
        rf_w_en   = mem_ready;
      end
      S_ADD, S_SUB: begin
        rf_ra_addr = fld_a_s;
        rf_rb_addr = fld_b_s;
        rf_w_addr  = fld_d_s;
        alu_sel    = (state_r == S_ADD) ? ALU_ADD : ALU_SUB;
        rf_sel     = 2'd0;
        rf_w_en    = 1'b1;
      end
      S_LDC: begin
        rf_imm    = fld_hi_s;
        rf_sel    = 2'd2;
        rf_w_addr = fld_d_s;
        rf_w_en   = 1'b1;
      end
      // Offset is applied to the already-incremented PC
      S_JPZ: begin
        rf_ra_addr = fld_a_s;
        pc_offset  = fld_lo_s;
        pc_ld      = rf_ra_zero;
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_unit_v2.sv
// Bench for control_unit_v2: instruction-level model expands each instruction into
// its expected per-cycle output trace; one negedge process compares DUT against it.
module tb_control_unit_v2;

  logic        clk;
  logic        reset;
  logic [15:0] ir;
  logic        rf_ra_zero;
  logic        mem_ready;
  logic        pc_clr, pc_up, pc_ld, ir_ld, d_wr, rf_w_en, halted, illegal;
  logic [7:0]  pc_offset, d_addr, rf_imm;
  logic [1:0]  rf_sel;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state;
  logic [2:0]  alu_sel;
  logic [15:0] retired;

  control_unit_v2 dut (
    .clk(clk), .reset(reset), .ir(ir), .rf_ra_zero(rf_ra_zero), .mem_ready(mem_ready),
    .pc_clr(pc_clr), .pc_up(pc_up), .pc_ld(pc_ld), .pc_offset(pc_offset), .ir_ld(ir_ld),
    .d_addr(d_addr), .d_wr(d_wr), .rf_sel(rf_sel), .rf_imm(rf_imm), .rf_w_addr(rf_w_addr),
    .rf_w_en(rf_w_en), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr), .alu_sel(alu_sel),
    .halted(halted), .illegal(illegal), .retired(retired), .state(state)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic        pc_clr, pc_up, pc_ld;
    logic [7:0]  pc_off;
    logic        ir_ld;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic [1:0]  rf_sel;
    logic [7:0]  rf_imm;
    logic [3:0]  w_addr;
    logic        w_en;
    logic [3:0]  ra, rb;
    logic [2:0]  alu;
    logic        halted, illegal;
    logic [15:0] retired;
  } out_t;

  typedef struct {
    bit          check;
    int          tag;
    logic        rst;
    logic [15:0] ir;
    logic        mr;
    logic        zero;
    out_t        e;
  } cyc_t;

  cyc_t plan[$];
  cyc_t cur;
  bit   active;
  int   cidx;
  int   vectors;
  int   miscompares;
  int   load_pulses;
  int   m_ret;
  bit   m_ill;
  int   pend;
  out_t act;

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic cyc_t blank(input logic [15:0] i, input logic mr, input logic z);
    cyc_t c;
    c.check = 1'b1;
    c.tag   = 0;
    c.rst   = 1'b0;
    c.ir    = i;
    c.mr    = mr;
    c.zero  = z;
    c.e     = '0;
    c.e.retired = m_ret[15:0];
    c.e.illegal = m_ill;
    return c;
  endfunction

  task automatic do_reset();
    cyc_t c;
    c = blank(16'h0000, 1'b0, 1'b0);
    c.rst = 1'b1;
    c.check = 1'b0;
    plan.push_back(c);
    m_ret = 0;
    m_ill = 1'b0;
    c = blank(16'h0000, 1'b0, 1'b0);
    c.e.st = 4'd0;
    c.e.pc_clr = 1'b1;
    c.tag = 10;
    plan.push_back(c);
  endtask

  task automatic fetch_decode(input logic [15:0] i, input logic z);
    cyc_t c;
    c = blank(i, 1'b0, z);
    c.e.st = 4'd1;
    c.e.pc_up = 1'b1;
    c.e.ir_ld = 1'b1;
    c.tag = pend;
    pend = 0;
    plan.push_back(c);
    c = blank(i, 1'b0, z);
    c.e.st = 4'd2;
    plan.push_back(c);
  endtask

  // Expands one instruction into its cycles; a HALT-class opcode holds for halt_n cycles
  task automatic run_instr(input logic [15:0] i, input int stalls, input logic z,
                           input int tag, input int halt_n);
    cyc_t c;
    logic [3:0] op, a, b, d;
    logic [7:0] lo, hi;
    op = i[15:12]; a = i[11:8]; b = i[7:4]; d = i[3:0]; lo = i[7:0]; hi = i[11:4];
    fetch_decode(i, z);
    case (op)
      4'd0: begin
        c = blank(i, 1'b0, z); c.e.st = 4'd3; c.tag = tag; plan.push_back(c);
      end
      4'd1: begin
        for (int k = 0; k <= stalls; k++) begin
          c = blank(i, (k == stalls), z);
          c.e.st = 4'd6; c.e.d_addr = lo; c.e.ra = a; c.e.d_wr = 1'b1; c.tag = tag;
          plan.push_back(c);
        end
      end
      4'd2: begin
        c = blank(i, 1'b1, z);
        c.e.st = 4'd4; c.e.d_addr = hi; c.e.rf_sel = 2'd1; c.e.w_addr = d; c.tag = tag;
        plan.push_back(c);
        for (int k = 0; k <= stalls; k++) begin
          c = blank(i, (k == stalls), z);
          c.e.st = 4'd5; c.e.d_addr = hi; c.e.rf_sel = 2'd1; c.e.w_addr = d;
          c.e.w_en = (k == stalls); c.tag = tag;
          plan.push_back(c);
        end
      end
      4'd3, 4'd4: begin
        c = blank(i, 1'b0, z);
        c.e.st = (op == 4'd3) ? 4'd7 : 4'd8;
        c.e.alu = (op == 4'd3) ? 3'd1 : 3'd2;
        c.e.ra = a; c.e.rb = b; c.e.w_addr = d; c.e.w_en = 1'b1; c.tag = tag;
        plan.push_back(c);
      end
      4'd6: begin
        c = blank(i, 1'b0, z);
        c.e.st = 4'd10; c.e.rf_imm = hi; c.e.rf_sel = 2'd2; c.e.w_addr = d; c.e.w_en = 1'b1;
        c.tag = tag;
        plan.push_back(c);
      end
      4'd7: begin
        c = blank(i, 1'b0, z);
        c.e.st = 4'd11; c.e.ra = a; c.e.pc_off = lo; c.e.pc_ld = z; c.tag = tag;
        plan.push_back(c);
      end
      default: begin
        if (op != 4'd5) m_ill = 1'b1;
        for (int k = 0; k < halt_n; k++) begin
          c = blank(i, k[0], z);
          c.e.st = 4'd9; c.e.halted = 1'b1; c.tag = tag;
          plan.push_back(c);
        end
        return;
      end
    endcase
    if (m_ret < 65535) m_ret = m_ret + 1;
  endtask

  // Reset arrives while a store is still waiting on memory
  task automatic store_abort(input logic [15:0] i, input int n);
    cyc_t c;
    fetch_decode(i, 1'b0);
    for (int k = 0; k < n; k++) begin
      c = blank(i, 1'b0, 1'b0);
      c.e.st = 4'd6; c.e.d_addr = i[7:0]; c.e.ra = i[11:8]; c.e.d_wr = 1'b1;
      plan.push_back(c);
    end
    do_reset();
  endtask

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h required %h", name, cidx, got, want);
    end
  endtask

  // Per-cycle compare against the model trace plus literal spot checks
  always @(negedge clk) begin
    if (active && cur.check) begin
      act = {state, pc_clr, pc_up, pc_ld, pc_offset, ir_ld, d_addr, d_wr, rf_sel, rf_imm,
             rf_w_addr, rf_w_en, rf_ra_addr, rf_rb_addr, alu_sel, halted, illegal, retired};
      vectors++;
      if (act !== cur.e) begin
        miscompares++;
        $display("FAIL trace cycle %0d ir=%h: got %h required %h", cidx, cur.ir, act, cur.e);
      end
      if (cur.tag == 3 && rf_w_en === 1'b1) load_pulses++;
      case (cur.tag)
        1: lit("noop_retired", retired, 16'd1);
        2: begin
          lit("store_state", {12'd0, state}, 16'd6);
          lit("store_daddr", {8'd0, d_addr}, 16'h0029);
          lit("store_ra", {12'd0, rf_ra_addr}, 16'h000F);
          lit("store_dwr", {15'd0, d_wr}, 16'd1);
        end
        3: begin
          lit("load_daddr", {8'd0, d_addr}, 16'h000A);
          lit("load_rfsel", {14'd0, rf_sel}, 16'd1);
          lit("load_waddr", {12'd0, rf_w_addr}, 16'd7);
        end
        4, 5: begin
          lit("alu_ra", {12'd0, rf_ra_addr}, 16'd1);
          lit("alu_rb", {12'd0, rf_rb_addr}, 16'd2);
          lit("alu_waddr", {12'd0, rf_w_addr}, 16'd3);
          lit("alu_wen", {15'd0, rf_w_en}, 16'd1);
          lit("alu_sel", {13'd0, alu_sel}, (cur.tag == 4) ? 16'd1 : 16'd2);
        end
        6: begin
          lit("ldc_imm", {8'd0, rf_imm}, 16'h00AB);
          lit("ldc_rfsel", {14'd0, rf_sel}, 16'd2);
          lit("ldc_waddr", {12'd0, rf_w_addr}, 16'd5);
        end
        7: begin
          lit("jpz_taken_ld", {15'd0, pc_ld}, 16'd1);
          lit("jpz_offset", {8'd0, pc_offset}, 16'h00FE);
        end
        8: lit("jpz_not_taken_ld", {15'd0, pc_ld}, 16'd0);
        9: begin
          lit("halt_state", {12'd0, state}, 16'd9);
          lit("halt_flags", {14'd0, halted, illegal}, 16'd3);
          lit("halt_retired", retired, 16'd8);
        end
        10: begin
          lit("init_state", {12'd0, state}, 16'd0);
          lit("init_pcclr", {15'd0, pc_clr}, 16'd1);
          lit("init_retired", retired, 16'd0);
          lit("init_illegal", {15'd0, illegal}, 16'd0);
        end
        default: ;
      endcase
    end
  end

  initial begin
    vectors = 0; miscompares = 0; load_pulses = 0;
    m_ret = 0; m_ill = 1'b0; pend = 0; active = 1'b0; cidx = 0;
    reset = 1'b1; ir = 16'h0000; mem_ready = 1'b0; rf_ra_zero = 1'b0;

    do_reset();
    run_instr(16'h0000, 0, 1'b0, 0, 0);
    pend = 1;
    run_instr(16'h1F29, 2, 1'b0, 2, 0);
    run_instr(16'h20A7, 1, 1'b0, 3, 0);
    run_instr(16'h3123, 0, 1'b0, 4, 0);
    run_instr(16'h4123, 0, 1'b0, 5, 0);
    run_instr(16'h6AB5, 0, 1'b0, 6, 0);
    run_instr(16'h73FE, 0, 1'b1, 7, 0);
    run_instr(16'h73FE, 0, 1'b0, 8, 0);
    run_instr(16'h9000, 0, 1'b0, 9, 10);
    do_reset();
    run_instr(16'h0000, 0, 1'b0, 0, 0);
    run_instr(16'h1C42, 0, 1'b0, 0, 0);
    run_instr(16'h2E51, 0, 1'b0, 0, 0);
    run_instr(16'h6123, 0, 1'b0, 0, 0);
    store_abort(16'h1A5C, 2);
    run_instr(16'h3456, 0, 1'b0, 0, 0);
    run_instr(16'h5000, 0, 1'b0, 0, 4);
    do_reset();
    run_instr(16'hF123, 0, 1'b0, 0, 3);

    for (int i = 0; i < plan.size(); i++) begin
      reset      = plan[i].rst;
      ir         = plan[i].ir;
      mem_ready  = plan[i].mr;
      rf_ra_zero = plan[i].zero;
      cur        = plan[i];
      cidx       = i;
      active     = 1'b1;
      @(posedge clk);
      #1;
    end
    active = 1'b0;
    cidx = plan.size();
    lit("load_wen_pulses", load_pulses[15:0], 16'd1);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
